// File: rtl/debouncer_pkg.sv
// Shared helpers and types for the multi-channel debouncer.
package debouncer_pkg;

  // Field width of the per-channel counters in ch_state_t; StableTime and
  // HoldTime must stay below 2**CntW ms.
  localparam int unsigned CntW = 16;

  // Bits needed to hold a millisecond count of 0..ms.
  function automatic int unsigned ms_to_cnt_width(input int unsigned ms);
    return $clog2(ms + 1);
  endfunction

  // Clock cycles in one millisecond.
  function automatic int unsigned cycles_per_ms(input int unsigned clk_freq);
    return clk_freq / 1000;
  endfunction

  // Per-channel state, grouped so it reads as one bundle in waveforms.
  typedef struct packed {
    logic            level;
    logic            done;
    logic [CntW-1:0] stable_cnt;
    logic [CntW-1:0] hold_cnt;
  } ch_state_t;

endpackage

// File: rtl/debouncer_ch.sv
// One debounce channel: synchronizer, ms-paced debounce filter, registered
// rise/fall pulses and a one-shot long-press tick.
module debouncer_ch
  import debouncer_pkg::*;
#(
  parameter int unsigned StableTime = 10,
  parameter int unsigned HoldTime   = 1000,
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  input  logic ms_tick_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_tick_o
);

  localparam int unsigned StableW = ms_to_cnt_width(StableTime);
  localparam int unsigned HoldW   = ms_to_cnt_width(HoldTime);

  logic [SyncStages-1:0] sync_q;
  logic                  sync;
  ch_state_t             state_q;
  ch_state_t             state_d;
  logic                  rise_d;
  logic                  fall_d;
  logic                  long_d;
  logic                  rise_q;
  logic                  fall_q;
  logic                  long_q;
  logic [StableW-1:0]    stable_inc;
  logic [HoldW-1:0]      hold_inc;
  logic                  stable_last;
  logic                  hold_last;

  assign sync = sync_q[SyncStages-1];

  // Synchronizer chain, state and output pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SyncStages-2:0], raw_i};
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      long_q  <= long_d;
    end
  end

  // Debounce window and long-press counting. Counters are rebuilt from their
  // low StableW/HoldW bits on every path so the upper struct bits stay zero.
  always_comb begin
    state_d            = state_q;
    state_d.stable_cnt = CntW'(state_q.stable_cnt[StableW-1:0]);
    state_d.hold_cnt   = CntW'(state_q.hold_cnt[HoldW-1:0]);
    rise_d             = 1'b0;
    fall_d             = 1'b0;
    long_d             = 1'b0;
    stable_inc         = state_q.stable_cnt[StableW-1:0] + StableW'(1);
    hold_inc           = state_q.hold_cnt[HoldW-1:0] + HoldW'(1);
    stable_last        = (state_q.stable_cnt == CntW'(StableTime - 1));
    hold_last          = (state_q.hold_cnt == CntW'(HoldTime - 1));

    if (sync == state_q.level) begin
      state_d.stable_cnt = '0;
    end else if (ms_tick_i) begin
      if (stable_last) begin
        state_d.level      = sync;
        state_d.stable_cnt = '0;
        rise_d             = sync;
        fall_d             = ~sync;
      end else begin
        state_d.stable_cnt = CntW'(stable_inc);
      end
    end

    if (!state_q.level) begin
      state_d.hold_cnt = '0;
      state_d.done     = 1'b0;
    end else if (!state_q.done && ms_tick_i) begin
      if (hold_last) begin
        state_d.done = 1'b1;
        long_d       = ~fall_d;
      end else begin
        state_d.hold_cnt = CntW'(hold_inc);
      end
    end
  end

  assign level_o     = state_q.level;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign long_tick_o = long_q;

endmodule

// File: rtl/debouncer_multi.sv
// Bank of independent debounce channels sharing one 1 ms prescaler.
module debouncer_multi
  import debouncer_pkg::*;
#(
  parameter int unsigned      NumCh      = 4,
  parameter int unsigned      ClkFreq    = 100_000_000,
  parameter int unsigned      StableTime = 10,
  parameter int unsigned      HoldTime   = 1000,
  parameter int unsigned      SyncStages = 2,
  parameter logic [NumCh-1:0] InvertMask = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NumCh-1:0] sw_i,
  output logic [NumCh-1:0] db_level_o,
  output logic [NumCh-1:0] db_rise_o,
  output logic [NumCh-1:0] db_fall_o,
  output logic [NumCh-1:0] long_tick_o,
  output logic             any_change_o
);

  localparam int unsigned P  = cycles_per_ms(ClkFreq);
  localparam int unsigned PW = $clog2(P);

  logic [PW-1:0]    pre_cnt;
  logic             ms_tick;
  logic [NumCh-1:0] raw;

  assign ms_tick = (pre_cnt == PW'(P - 1));
  assign raw     = sw_i ^ InvertMask;

  // Free-running millisecond prescaler.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt <= '0;
    end else if (ms_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  for (genvar i = 0; i < int'(NumCh); i++) begin : g_ch
    debouncer_ch #(
      .StableTime (StableTime),
      .HoldTime   (HoldTime),
      .SyncStages (SyncStages)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .raw_i       (raw[i]),
      .ms_tick_i   (ms_tick),
      .level_o     (db_level_o[i]),
      .rise_o      (db_rise_o[i]),
      .fall_o      (db_fall_o[i]),
      .long_tick_o (long_tick_o[i])
    );
  end

  assign any_change_o = |(db_rise_o | db_fall_o);

endmodule

// File: tb/tb_debouncer_multi.sv
// Self-checking bench for debouncer_multi: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_debouncer_multi;

  localparam int unsigned     NCH = 2;
  localparam int unsigned     CLK = 10_000;
  localparam int unsigned     ST  = 3;
  localparam int unsigned     HT  = 8;
  localparam int unsigned     SS  = 2;
  localparam int unsigned     P   = 10;
  localparam logic [NCH-1:0]  INV = 2'b10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] sw  = 2'b10;
  logic [NCH-1:0] level, rise, fall, longt;
  logic           any;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  debouncer_multi #(
    .NumCh      (NCH),
    .ClkFreq    (CLK),
    .StableTime (ST),
    .HoldTime   (HT),
    .SyncStages (SS),
    .InvertMask (INV)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sw_i         (sw),
    .db_level_o   (level),
    .db_rise_o    (rise),
    .db_fall_o    (fall),
    .long_tick_o  (longt),
    .any_change_o (any)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int unsigned    since_rst;
  logic [NCH-1:0] sq [$];
  int unsigned    mism [NCH];
  int unsigned    held [NCH];
  bit             done [NCH];
  logic [NCH-1:0] m_level, m_rise, m_fall, m_long;

  int unsigned rise_cnt [NCH];
  int unsigned fall_cnt [NCH];
  int unsigned long_cnt [NCH];

  task automatic model_edge();
    logic           tick;
    logic [NCH-1:0] s;
    logic [NCH-1:0] nlev;
    bit             fall_now;
    if (rst) begin
      since_rst = 0;
      sq.delete();
      for (int unsigned k = 0; k < SS; k++) sq.push_back('0);
      for (int c = 0; c < NCH; c++) begin
        mism[c] = 0; held[c] = 0; done[c] = 0;
      end
      m_level = '0; m_rise = '0; m_fall = '0; m_long = '0;
    end else begin
      tick = ((since_rst % P) == P - 1);
      since_rst++;
      s = sq.pop_front();
      sq.push_back(sw ^ INV);
      nlev = m_level;
      m_rise = '0; m_fall = '0; m_long = '0;
      for (int c = 0; c < NCH; c++) begin
        fall_now = 0;
        // a level change needs ST consecutive ms ticks of disagreement
        if (s[c] != m_level[c]) begin
          if (tick) begin
            mism[c]++;
            if (mism[c] == ST) begin
              nlev[c] = s[c];
              mism[c] = 0;
              if (s[c]) m_rise[c] = 1'b1;
              else begin m_fall[c] = 1'b1; fall_now = 1; end
            end
          end
        end else begin
          mism[c] = 0;
        end
        // long press: the HT-th ms tick seen while high
        if (!m_level[c]) begin
          held[c] = 0; done[c] = 0;
        end else if (!done[c] && tick) begin
          held[c]++;
          if (held[c] == HT) begin
            done[c] = 1;
            m_long[c] = !fall_now;
          end
        end
      end
      m_level = nlev;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int unsigned n,
                             input int unsigned lo, input int unsigned hi);
    checks++;
    if (n < lo || n > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, n, lo, hi);
    end
  endtask

  // One clock: model follows the edge, DUT sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle", 32'({level, rise, fall, longt, any}),
          32'({m_level, m_rise, m_fall, m_long, |(m_rise | m_fall)}));
    for (int c = 0; c < NCH; c++) begin
      if (rise[c] === 1'b1)  rise_cnt[c]++;
      if (fall[c] === 1'b1)  fall_cnt[c]++;
      if (longt[c] === 1'b1) long_cnt[c]++;
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step();
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NCH; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; long_cnt[c] = 0;
    end
  endtask

  // Steps until level[ch] equals val or max cycles pass; n = cycles taken.
  task automatic wait_level(input int ch, input logic val, input int unsigned max,
                            output int unsigned n);
    n = 0;
    while (level[ch] !== val && n < max) begin
      step();
      n++;
    end
    if (level[ch] !== val) begin
      failures++;
      $display("FAIL wait_level ch%0d: got %b expected %b within %0d cycles", ch, level[ch], val, max);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic           rst;
    logic [NCH-1:0] sw;
    int unsigned    cycles;
    logic [NCH-1:0] exp_level;
    int unsigned    exp_rises;
    int unsigned    exp_falls;
  } vec_t;

  vec_t vecs [8];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int unsigned n;
    int unsigned first;
    int unsigned bad;
    int unsigned hold;

    vecs[0] = '{1'b1, 2'b10, 3,  2'b00, 0, 0};
    vecs[1] = '{1'b0, 2'b10, 40, 2'b00, 0, 0};
    vecs[2] = '{1'b0, 2'b11, 40, 2'b01, 1, 0};
    vecs[3] = '{1'b0, 2'b01, 40, 2'b11, 1, 0};
    vecs[4] = '{1'b0, 2'b00, 40, 2'b10, 0, 1};
    vecs[5] = '{1'b0, 2'b10, 40, 2'b00, 0, 1};
    vecs[6] = '{1'b0, 2'b11, 5,  2'b00, 0, 0};
    vecs[7] = '{1'b0, 2'b10, 40, 2'b00, 0, 0};

    rst = 1'b1;
    sw  = 2'b10;
    for (int v = 0; v < 8; v++) begin
      rst = vecs[v].rst;
      sw  = vecs[v].sw;
      clear_counts();
      run(vecs[v].cycles);
      check($sformatf("vec%0d_level", v), 32'(level), 32'(vecs[v].exp_level));
      check($sformatf("vec%0d_rises", v), rise_cnt[0] + rise_cnt[1], vecs[v].exp_rises);
      check($sformatf("vec%0d_falls", v), fall_cnt[0] + fall_cnt[1], vecs[v].exp_falls);
    end

    // Clean press on channel 0.
    sw[0] = 1'b1;
    wait_level(0, 1'b1, 40, n);
    check_range("clean_latency", n, 23, 32);
    check("clean_rise", 32'(rise), 32'(2'b01));
    check("clean_any", 32'(any), 32'(1));
    step();
    check("clean_rise_gone", 32'({rise, any}), 32'(0));

    // Bounce: toggle every 7 cycles for 60 cycles, then settle high.
    sw[0] = 1'b0;
    wait_level(0, 1'b0, 40, n);
    run(2);
    clear_counts();
    bad = 0;
    for (int unsigned k = 0; k < 60; k++) begin
      if (k % 7 == 0) sw[0] = ~sw[0];
      step();
      if (level[0] !== 1'b0) bad++;
    end
    check("bounce_stable", bad, 0);
    sw[0] = 1'b1;
    wait_level(0, 1'b1, 40, n);
    check_range("bounce_latency", n, 23, 32);
    run(5);
    check("bounce_single_rise", rise_cnt[0], 1);

    // Long press: exactly one tick, 71..80 cycles after the rise.
    sw[0] = 1'b0;
    wait_level(0, 1'b0, 40, n);
    sw[0] = 1'b1;
    wait_level(0, 1'b1, 40, n);
    clear_counts();
    first = 0;
    for (int unsigned k = 1; k <= 150; k++) begin
      step();
      if (longt[0] === 1'b1 && first == 0) first = k;
    end
    check_range("long_delay", first, 71, 80);
    check("long_once", long_cnt[0], 1);
    sw[0] = 1'b0;
    wait_level(0, 1'b0, 40, n);
    run(2);
    check("long_release_fall", fall_cnt[0], 1);
    sw[0] = 1'b1;
    wait_level(0, 1'b1, 40, n);
    clear_counts();
    run(90);
    check("long_repress", long_cnt[0], 1);

    // Active-low channel held inactive through reset.
    sw  = 2'b10;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    bad = 0;
    for (int unsigned k = 0; k < 40; k++) begin
      step();
      if (level !== 2'b00) bad++;
    end
    check("active_low_idle", bad, 0);
    sw[1] = 1'b0;
    wait_level(1, 1'b1, 40, n);
    check_range("active_low_latency", n, 23, 32);
    run(3);

    // Reset while channel 0 is two ms into its window.
    sw[0] = 1'b1;
    n = 0;
    while (mism[0] != 2 && n < 40) begin step(); n++; end
    check("midreset_reached", mism[0], 2);
    clear_counts();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset_outputs", 32'({level, rise, fall, longt, any}), 32'(0));
    wait_level(0, 1'b1, 40, n);
    check_range("midreset_latency", n, 23, 32);
    check("midreset_no_fall", fall_cnt[0] + fall_cnt[1], 0);

    // Both channels rise together.
    sw = 2'b10;
    run(40);
    sw = 2'b01;
    n = 0;
    while (level !== 2'b11 && n < 40) begin step(); n++; end
    check("simul_rise", 32'(rise), 32'(2'b11));
    check("simul_any", 32'(any), 32'(1));
    step();
    check("simul_any_gone", 32'(any), 32'(0));

    // Randomized traffic, checked every cycle against the model.
    for (int unsigned it = 0; it < 80; it++) begin
      sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      hold = ($urandom_range(0, 9) == 0) ? $urandom_range(90, 130) : $urandom_range(1, 40);
      run(hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
